// File: rtl/mac_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_result_writer
// Brief    : Avalon-MM write master that snapshots N MAC accumulators and
//            writes them out as packed 64-bit words (two lanes per word).
//            Optional macro RESULT_CHECKSUM_EN appends a {N, sum} word.
// Revision : 1.0  initial release
// ============================================================================
module mac_result_writer #(
    parameter int          DATA_WIDTH = 8,
    parameter int          N          = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0010
) (
    input  logic                    CLOCK_50,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3*DATA_WIDTH-1:0] c_in [0:N-1],
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             avm_address,
    output logic                    avm_write,
    output logic [63:0]             avm_writedata,
    output logic [7:0]              avm_byteenable,
    input  logic                    avm_waitrequest,
    output logic [1:0]              dbg_state
);

    localparam int RW  = 3 * DATA_WIDTH;
    localparam int PAD = 32 - RW;
`ifdef RESULT_CHECKSUM_EN
    localparam int WORDS = N / 2 + 1;
`else
    localparam int WORDS = N / 2;
`endif
    localparam int             CW         = $clog2(WORDS + 1);
    localparam logic [CW-1:0]  C_LAST_IDX = CW'(WORDS - 1);

    generate
        if ((N % 2) != 0) begin : g_n_odd
            $error("mac_result_writer: N must be even");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    function automatic logic [63:0] pack_pair(input logic [RW-1:0] lo, input logic [RW-1:0] hi);
        return {{PAD{1'b0}}, hi, {PAD{1'b0}}, lo};
    endfunction

    state_t         r_state, w_state;
    logic [RW-1:0]  r_snap [0:N-1];
    logic [CW-1:0]  r_idx, w_idx, w_next_idx;
    logic           r_busy, w_busy;
    logic           r_done, w_done;
    logic           r_write, w_write;
    logic [31:0]    r_addr, w_addr;
    logic [63:0]    r_data, w_data, w_next_data;
    logic [7:0]     r_be, w_be;
    logic           w_capture;

`ifdef RESULT_CHECKSUM_EN
    logic [31:0]    w_checksum;

    always_comb begin
        w_checksum = '0;
        for (int i = 0; i < N; i++) begin
            w_checksum = w_checksum + 32'(r_snap[i]);
        end
    end
`endif

    // Data for the word that follows the one currently on the bus
    always_comb begin
        w_next_idx  = r_idx + 1'b1;
        w_next_data = '0;
        for (int k = 0; k < N / 2; k++) begin
            if (w_next_idx == CW'(k)) begin
                w_next_data = pack_pair(r_snap[2*k], r_snap[2*k+1]);
            end
        end
`ifdef RESULT_CHECKSUM_EN
        if (w_next_idx == CW'(N / 2)) begin
            w_next_data = {32'(N), w_checksum};
        end
`endif
    end

    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_busy    = r_busy;
        w_done    = r_done;
        w_write   = r_write;
        w_addr    = r_addr;
        w_data    = r_data;
        w_capture = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_done = 1'b0;
                if (start) begin
                    w_state = S_CAPTURE;
                    w_busy  = 1'b1;
                end
            end
            S_CAPTURE: begin
                // Word 0 comes straight from c_in, which the snapshot latches on this same edge
                w_capture = 1'b1;
                w_state   = S_WRITE;
                w_write   = 1'b1;
                w_idx     = '0;
                w_addr    = BASE_ADDR;
                w_data    = pack_pair(c_in[0], c_in[1]);
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    if (r_idx == C_LAST_IDX) begin
                        w_state = S_DONE;
                        w_write = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_idx  = w_next_idx;
                        w_addr = r_addr + 32'd1;
                        w_data = w_next_data;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state = S_IDLE;
                    w_done  = 1'b0;
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_be = w_write ? 8'hFF : 8'h00;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_data  <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_write <= w_write;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_be    <= w_be;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_capture) begin
            r_snap <= c_in;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign avm_write      = r_write;
    assign avm_address    = r_addr;
    assign avm_writedata  = r_data;
    assign avm_byteenable = r_be;
    assign dbg_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_result_writer
// Brief    : Scoreboard bench for mac_result_writer with a word-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mac_result_writer;

    localparam int          N    = 8;
    localparam int          DW   = 8;
    localparam int          RW   = 3 * DW;
    localparam logic [31:0] BASE = 32'h0000_0010;
`ifdef RESULT_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          CLOCK_50;
    logic          rst_n;
    logic          start;
    logic [RW-1:0] c_in [0:N-1];
    logic          busy;
    logic          done;
    logic [31:0]   avm_address;
    logic          avm_write;
    logic [63:0]   avm_writedata;
    logic [7:0]    avm_byteenable;
    logic          avm_waitrequest;
    logic [1:0]    dbg_state;

    mac_result_writer #(.DATA_WIDTH(DW), .N(N), .BASE_ADDR(BASE)) dut (
        .CLOCK_50       (CLOCK_50),
        .rst_n          (rst_n),
        .start          (start),
        .c_in           (c_in),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .dbg_state      (dbg_state)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic rand_wait = 1'b0;

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
        if (rand_wait) avm_waitrequest = ($urandom_range(0, 2) == 0);
    endtask

    // Reference: lane pairs zero-extended to 32 bits, consecutive addresses, optional {N, sum}
    task automatic push_expected();
        exp_t        e;
        logic [31:0] sum;
        sum = '0;
        for (int k = 0; k < N / 2; k++) begin
            e.addr = BASE + k;
            e.data = {32'(c_in[2*k+1]), 32'(c_in[2*k])};
            sb.push_back(e);
        end
        for (int i = 0; i < N; i++) sum += 32'(c_in[i]);
        if (EXTRA == 1) begin
            e.addr = BASE + N / 2;
            e.data = {32'(N), sum};
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name, input int n0, input int exp_lat);
        int n;
        n = n0;
        do begin
            step();
            n++;
        end while (!done && n < 400);
        chk({name, " done"}, 64'(done), 64'd1);
        if (exp_lat > 0) chk({name, " latency"}, 64'(n), 64'(exp_lat));
        chk({name, " all words written"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic finish_pass(input string name);
        rand_wait       = 1'b0;
        avm_waitrequest = 1'b0;
        step();
        step();
        chk({name, " done held"}, 64'(done), 64'd1);
        chk({name, " dbg done"}, 64'(dbg_state), 64'd3);
        start = 1'b0;
        step();
        chk({name, " done drop"}, 64'(done), 64'd0);
        chk({name, " back idle"}, 64'(dbg_state), 64'd0);
    endtask

    // Monitor: Avalon protocol checks and scoreboard comparison
    initial begin
        logic        prev_stall;
        logic [31:0] pa;
        logic [63:0] pd;
        exp_t        e;
        prev_stall = 1'b0;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge CLOCK_50);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall write held", 64'(avm_write), 64'd1);
                    chk("stall addr held", 64'(avm_address), 64'(pa));
                    chk("stall data held", avm_writedata, pd);
                end
                if (avm_write) begin
                    chk("byteenable active", 64'(avm_byteenable), 64'hFF);
                    if (!avm_waitrequest) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected write: addr %h data %h, none expected", avm_address, avm_writedata);
                        end else begin
                            e = sb.pop_front();
                            chk("write addr", 64'(avm_address), 64'(e.addr));
                            chk("write data", avm_writedata, e.data);
                        end
                    end
                end else begin
                    chk("byteenable idle", 64'(avm_byteenable), 64'h00);
                end
                prev_stall = avm_write && avm_waitrequest;
                pa = avm_address;
                pd = avm_writedata;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary forced");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < N; i++) c_in[i] = '0;

        // Reset state
        step();
        step();
        chk("reset avm_write", 64'(avm_write), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset address", 64'(avm_address), 64'h10);
        chk("reset dbg_state", 64'(dbg_state), 64'd0);
        chk("reset writedata", avm_writedata, 64'd0);
        chk("reset byteenable", 64'(avm_byteenable), 64'd0);
        rst_n = 1'b1;
        step();

        // Ramp pattern, no stalls
        for (int i = 0; i < N; i++) c_in[i] = RW'(24'h000100 * (i + 1));
        start = 1'b1;
        push_expected();
        wait_done("ramp", 0, 6 + EXTRA);
        finish_pass("ramp");

        // Three stall cycles on word 1
        start = 1'b1;
        push_expected();
        step();
        step();
        step();
        chk("stall busy", 64'(busy), 64'd1);
        chk("stall word1 addr", 64'(avm_address), 64'h11);
        avm_waitrequest = 1'b1;
        step();
        step();
        step();
        avm_waitrequest = 1'b0;
        wait_done("stall", 6, 9 + EXTRA);
        finish_pass("stall");

        // c_in changes after capture must not reach the bus
        start = 1'b1;
        push_expected();
        step();
        step();
        for (int i = 0; i < N; i++) c_in[i] = 24'hFFFFFF;
        wait_done("snapshot", 2, 6 + EXTRA);
        finish_pass("snapshot");

        // Reset during word 2, then a full restart
        for (int i = 0; i < N; i++) c_in[i] = RW'(24'h000100 * (i + 1));
        start = 1'b1;
        push_expected();
        step();
        step();
        step();
        step();
        chk("word2 addr before reset", 64'(avm_address), 64'h12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset avm_write", 64'(avm_write), 64'd0);
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset address", 64'(avm_address), 64'h10);
        chk("async reset dbg_state", 64'(dbg_state), 64'd0);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        push_expected();
        wait_done("restart", 0, 6 + EXTRA);
        finish_pass("restart");

`ifdef RESULT_CHECKSUM_EN
        // Saturated lanes: checksum word {8, 8*FFFFFF}
        for (int i = 0; i < N; i++) c_in[i] = 24'hFFFFFF;
        start = 1'b1;
        push_expected();
        wait_done("checksum", 0, 7);
        finish_pass("checksum");
`endif

        // Random data with random slave stalls
        for (int p = 0; p < 16; p++) begin
            for (int i = 0; i < N; i++) c_in[i] = RW'($urandom);
            if (p % 4 == 3) c_in[$urandom_range(0, N - 1)] = 24'hFFFFFF;
            rand_wait = 1'b1;
            start     = 1'b1;
            push_expected();
            wait_done("random", 0, 0);
            finish_pass("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
